vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_pkg.sv | 15 +
 rtl/fb_pixel_fifo.sv | 56 +++++
 rtl/vga_fb_arbiter.sv | 117 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter and its pixel FIFO.
package vga_fb_pkg;

    localparam int FB_PIXELS_DEF = 19200;  // 160x120
    localparam int ADDR_W_DEF    = 15;
    localparam int PIX_W         = 3;      // {r, g, b}

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE,
        ARB_FLUSH
    } arb_op_e;

endpackage

// File: rtl/fb_pixel_fifo.sv
// Show-ahead pixel FIFO between the SRAM read port and the display; flush wins over push and pop.
module fb_pixel_fifo
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [PIX_W-1:0] wdata,
    input  logic             pop,
    output logic [PIX_W-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is a no-op here; the arbiter flags it.
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer SRAM arbiter: keeps the display FIFO topped up and slots host writes in between.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FB_PIXELS  = FB_PIXELS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WATER  = 4
) (
    input  logic              clk_50Mhz,
    input  logic              reset,
    input  logic              i_frame_start,
    input  logic              i_fetch_next_pixel,
    output logic              o_pixel_r,
    output logic              o_pixel_g,
    output logic              o_pixel_b,
    output logic              o_underflow,
    input  logic              i_host_wr_req,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [PIX_W-1:0]  i_host_data,
    output logic              o_host_wr_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [PIX_W-1:0]  o_mem_wdata,
    input  logic [PIX_W-1:0]  i_mem_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LVL_W = CNT_W + 1;

    arb_op_e           op;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_vld_p0;  // read on the SRAM bus this cycle
    logic              rd_vld_p1;  // its data is on i_mem_rdata this cycle
    logic [CNT_W-1:0]  fifo_count;
    logic [LVL_W-1:0]  level;
    logic [PIX_W-1:0]  head;
    logic              host_ok;
    logic              host_in_range;

    function automatic logic [ADDR_W-1:0] next_rd_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(FB_PIXELS - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    assign rd_vld_p0     = o_mem_en & ~o_mem_we;
    assign level         = LVL_W'(fifo_count) + LVL_W'(rd_vld_p0) + LVL_W'(rd_vld_p1);
    // The request that was just acked is still held this cycle; it must not be serviced twice.
    assign host_ok       = i_host_wr_req & ~o_host_wr_ack;
    assign host_in_range = ({1'b0, i_host_addr} < (ADDR_W + 1)'(FB_PIXELS));

    always_comb begin
        op = ARB_IDLE;
        if (i_frame_start)                         op = ARB_FLUSH;
        else if (level < LVL_W'(LOW_WATER))        op = ARB_READ;
        else if (host_ok)                          op = ARB_WRITE;
        else if (level < LVL_W'(FIFO_DEPTH))       op = ARB_READ;
    end

    // Stage p0 -> p1: issue the chosen access onto the registered SRAM bus
    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            o_mem_en      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wdata   <= '0;
            o_host_wr_ack <= 1'b0;
            o_underflow   <= 1'b0;
            rd_addr       <= '0;
            rd_vld_p1     <= 1'b0;
        end else begin
            o_mem_en      <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_wdata   <= '0;
            o_host_wr_ack <= 1'b0;
            rd_vld_p1     <= rd_vld_p0 & (op != ARB_FLUSH);
            case (op)
                ARB_FLUSH: begin
                    rd_addr     <= '0;
                    o_underflow <= 1'b0;
                end
                ARB_READ: begin
                    o_mem_en   <= 1'b1;
                    o_mem_addr <= rd_addr;
                    rd_addr    <= next_rd_addr(rd_addr);
                end
                ARB_WRITE: begin
                    o_mem_en      <= host_in_range;
                    o_mem_we      <= host_in_range;
                    o_mem_addr    <= i_host_addr;
                    o_mem_wdata   <= host_in_range ? i_host_data : '0;
                    o_host_wr_ack <= 1'b1;
                end
                default: ;
            endcase
            if (i_fetch_next_pixel && (fifo_count == '0) && (op != ARB_FLUSH)) o_underflow <= 1'b1;
        end
    end

    // Stage p1: returning read data lands in the display FIFO
    fb_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk_50Mhz),
        .rst   (reset),
        .flush (op == ARB_FLUSH),
        .push  (rd_vld_p1),
        .wdata (i_mem_rdata),
        .pop   (i_fetch_next_pixel),
        .head  (head),
        .count (fifo_count)
    );

    assign {o_pixel_r, o_pixel_g, o_pixel_b} = head;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter against a queue-based reference model with an SRAM model.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int FB    = FB_PIXELS_DEF;
    localparam int AW    = ADDR_W_DEF;
    localparam int DEPTH = 8;
    localparam int LW    = 4;
    localparam int MEMSZ = 1 << AW;

    localparam int HOST_OFF  = 0;
    localparam int HOST_ONE  = 1;
    localparam int HOST_RAND = 2;
    localparam int HOST_CONT = 3;

    logic              clk_50Mhz = 1'b0;
    logic              reset;
    logic              i_frame_start;
    logic              i_fetch_next_pixel;
    logic              o_pixel_r, o_pixel_g, o_pixel_b;
    logic              o_underflow;
    logic              i_host_wr_req;
    logic [AW-1:0]     i_host_addr;
    logic [PIX_W-1:0]  i_host_data;
    logic              o_host_wr_ack;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [AW-1:0]     o_mem_addr;
    logic [PIX_W-1:0]  o_mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;

    vga_fb_arbiter #(
        .FB_PIXELS  (FB),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH),
        .LOW_WATER  (LW)
    ) dut (
        .clk_50Mhz          (clk_50Mhz),
        .reset              (reset),
        .i_frame_start      (i_frame_start),
        .i_fetch_next_pixel (i_fetch_next_pixel),
        .o_pixel_r          (o_pixel_r),
        .o_pixel_g          (o_pixel_g),
        .o_pixel_b          (o_pixel_b),
        .o_underflow        (o_underflow),
        .i_host_wr_req      (i_host_wr_req),
        .i_host_addr        (i_host_addr),
        .i_host_data        (i_host_data),
        .o_host_wr_ack      (o_host_wr_ack),
        .o_mem_en           (o_mem_en),
        .o_mem_we           (o_mem_we),
        .o_mem_addr         (o_mem_addr),
        .o_mem_wdata        (o_mem_wdata),
        .i_mem_rdata        (mem_rdata)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    function automatic logic [PIX_W-1:0] init_pix(input int a);
        return PIX_W'((a * 5) ^ (a >> 4));
    endfunction

    // Synchronous single-port SRAM: read data valid the cycle after the access.
    logic [PIX_W-1:0] sram [MEMSZ];
    initial begin
        for (int i = 0; i < MEMSZ; i++) sram[AW'(i)] = init_pix(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk_50Mhz);
            if (o_mem_en) begin
                if (o_mem_we) sram[o_mem_addr] <= o_mem_wdata;
                else          mem_rdata <= sram[o_mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: FIFO contents, outstanding reads and the next expected bus cycle.
    typedef struct {
        int               step;
        logic [PIX_W-1:0] pix;
    } rd_t;

    logic [PIX_W-1:0] q [$];
    rd_t              fl [$];
    logic [PIX_W-1:0] ref_mem [MEMSZ];
    int               m_rd, m_step;
    logic             e_en, e_we, e_ack, e_uf;
    logic [AW-1:0]    e_addr;
    logic [PIX_W-1:0] e_wdata;

    int   host_mode = HOST_OFF;
    int   ack_seen  = 0;
    int   last_rd   = 0;
    logic saw_wrap  = 1'b0;

    task automatic model_reset();
        q.delete();
        fl.delete();
        m_rd = 0; m_step = 0;
        e_en = 0; e_we = 0; e_ack = 0; e_uf = 0;
        e_addr = '0; e_wdata = '0;
    endtask

    task automatic model_read();
        rd_t r;
        r.step = m_step;
        r.pix  = ref_mem[AW'(m_rd)];
        fl.push_back(r);
        e_en   = 1;
        e_addr = AW'(m_rd);
        m_rd   = (m_rd + 1) % FB;
    endtask

    task automatic model_step();
        int               level;
        logic             push, ack_now, host_ok;
        logic [PIX_W-1:0] pdata, pdump;
        rd_t              r;
        level   = q.size() + fl.size();
        ack_now = e_ack;
        host_ok = i_host_wr_req && !ack_now;
        push    = 0;
        pdata   = '0;
        if (fl.size() > 0 && fl[0].step == m_step - 2) begin
            r     = fl.pop_front();
            push  = 1;
            pdata = r.pix;
        end
        e_en = 0; e_we = 0; e_ack = 0; e_wdata = '0;
        if (i_frame_start) begin
            q.delete();
            fl.delete();
            e_uf = 0;
            m_rd = 0;
        end else begin
            if (i_fetch_next_pixel) begin
                if (q.size() == 0) e_uf = 1;
                else pdump = q.pop_front();
            end
            if (push) q.push_back(pdata);
            if (level < LW) model_read();
            else if (host_ok) begin
                e_ack = 1;
                if (int'(i_host_addr) < FB) begin
                    e_en = 1; e_we = 1;
                    e_addr = i_host_addr;
                    e_wdata = i_host_data;
                    ref_mem[i_host_addr] = i_host_data;
                end
            end else if (level < DEPTH) model_read();
        end
        m_step++;
    endtask

    task automatic check_outputs();
        logic [PIX_W-1:0] exp_pix;
        exp_pix = (q.size() > 0) ? q[0] : '0;
        chk("mem_en", 32'(o_mem_en), 32'(e_en));
        chk("mem_we", 32'(o_mem_we), 32'(e_we));
        if (e_en) chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(o_mem_wdata), 32'(e_wdata));
        chk("host_ack", 32'(o_host_wr_ack), 32'(e_ack));
        chk("pixel", 32'({o_pixel_r, o_pixel_g, o_pixel_b}), 32'(exp_pix));
        chk("underflow", 32'(o_underflow), 32'(e_uf));
    endtask

    task automatic new_host_req();
        i_host_wr_req = 1;
        i_host_addr   = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(FB, MEMSZ - 1))
                                                    : AW'($urandom_range(0, FB - 1));
        i_host_data   = PIX_W'($urandom_range(0, 7));
    endtask

    task automatic host_update();
        case (host_mode)
            HOST_ONE:  if (o_host_wr_ack) i_host_wr_req = 0;
            HOST_RAND: begin
                if (o_host_wr_ack) i_host_wr_req = 0;
                if (!i_host_wr_req && $urandom_range(0, 2) == 0) new_host_req();
            end
            HOST_CONT: if (o_host_wr_ack || !i_host_wr_req) new_host_req();
            default:   i_host_wr_req = 0;
        endcase
    endtask

    // Called at a falling edge: check this cycle, drive the next inputs, advance the model.
    task automatic tick(input logic fs, input logic pop);
        check_outputs();
        if (o_mem_en && !o_mem_we) begin
            if (last_rd == FB - 1 && o_mem_addr == '0) saw_wrap = 1;
            last_rd = int'(o_mem_addr);
        end
        if (o_host_wr_ack) ack_seen++;
        host_update();
        i_frame_start      = fs;
        i_fetch_next_pixel = pop;
        model_step();
        @(negedge clk_50Mhz);
    endtask

    task automatic host_one(input int addr, input logic [PIX_W-1:0] data);
        host_mode     = HOST_ONE;
        i_host_wr_req = 1;
        i_host_addr   = AW'(addr);
        i_host_data   = data;
    endtask

    initial begin
        int   n, nreads, ack0, first_rd;
        reset = 1;
        i_frame_start = 0; i_fetch_next_pixel = 0;
        i_host_wr_req = 0; i_host_addr = '0; i_host_data = '0;
        for (int i = 0; i < MEMSZ; i++) ref_mem[AW'(i)] = init_pix(i);
        model_reset();
        repeat (3) @(negedge clk_50Mhz);
        chk("rst_en",    32'(o_mem_en), 0);
        chk("rst_we",    32'(o_mem_we), 0);
        chk("rst_addr",  32'(o_mem_addr), 0);
        chk("rst_wdata", 32'(o_mem_wdata), 0);
        chk("rst_ack",   32'(o_host_wr_ack), 0);
        chk("rst_pix",   32'({o_pixel_r, o_pixel_g, o_pixel_b}), 0);
        chk("rst_uf",    32'(o_underflow), 0);
        reset = 0;

        // Fill from reset with no display or host traffic: reads 0..7 then idle.
        repeat (14) tick(0, 0);
        chk("fill_en",  32'(o_mem_en), 0);
        chk("fill_pix", 32'({o_pixel_r, o_pixel_g, o_pixel_b}), 32'(init_pix(0)));

        // Host write with the FIFO comfortably above the low-water mark.
        tick(0, 1);
        tick(0, 1);
        host_one(100, 3'b101);
        tick(0, 0);
        chk("wr_next_we",   32'(o_mem_we), 1);
        chk("wr_next_addr", 32'(o_mem_addr), 100);
        ack0 = ack_seen;
        repeat (4) tick(0, 0);
        chk("wr_ack_pulses", 32'(ack_seen - ack0), 1);
        chk("sram100", 32'(sram[100]), 32'(3'b101));

        // Pop on an empty FIFO right after a flush, then an out-of-range host write.
        host_mode = HOST_OFF;
        tick(1, 0);
        tick(0, 1);
        for (int i = 0; i < 6; i++) begin
            chk("uf_sticky", 32'(o_underflow), 1);
            tick(0, 0);
        end
        host_one(20000, 3'b111);
        n = 0;
        while (!o_host_wr_ack && n < 20) begin
            tick(0, 0);
            n++;
        end
        chk("oor_ack", 32'(o_host_wr_ack), 1);
        chk("oor_en",  32'(o_mem_en), 0);
        chk("oor_we",  32'(o_mem_we), 0);
        chk("oor_uf",  32'(o_underflow), 1);
        tick(0, 0);
        chk("oor_sram", 32'(sram[20000]), 32'(init_pix(20000)));

        // Frame start with a read in flight, a pop and a pending host write.
        repeat (4) tick(0, 0);
        tick(0, 1);
        tick(0, 0);
        host_one(300, PIX_W'($urandom_range(0, 7)));
        tick(1, 1);
        chk("flush_pix", 32'({o_pixel_r, o_pixel_g, o_pixel_b}), 0);
        chk("flush_uf",  32'(o_underflow), 0);
        chk("flush_en",  32'(o_mem_en), 0);
        n = 0; nreads = 0; first_rd = -1;
        while (!o_host_wr_ack && n < 20) begin
            if (o_mem_en && !o_mem_we) begin
                if (nreads == 0) first_rd = int'(o_mem_addr);
                nreads++;
            end
            tick(0, 0);
            n++;
        end
        chk("lw_ack",        32'(o_host_wr_ack), 1);
        chk("lw_reads",      32'(nreads), 4);
        chk("flush_rd_addr", 32'(first_rd), 0);

        // Random mix of pops, host writes and frame starts.
        host_mode = HOST_RAND;
        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));

        // Full frame: display pops every cycle while the host writes continuously.
        host_mode = HOST_CONT;
        tick(1, 0);
        repeat (12) tick(0, 0);
        saw_wrap = 0;
        last_rd  = 0;
        for (int i = 0; i < FB + 400; i++) tick(0, 1);
        chk("frame_uf",   32'(o_underflow), 0);
        chk("frame_wrap", 32'(saw_wrap), 1);

        // Reset asserted while a host write is on the bus.
        host_mode = HOST_OFF;
        tick(1, 0);
        repeat (12) tick(0, 0);
        host_one(200, ~init_pix(200));
        tick(0, 0);
        chk("abort_pre_we", 32'(o_mem_we), 1);
        reset = 1;
        i_host_wr_req = 0;
        #1;
        chk("abort_ack", 32'(o_host_wr_ack), 0);
        chk("abort_en",  32'(o_mem_en), 0);
        chk("abort_we",  32'(o_mem_we), 0);
        chk("abort_pix", 32'({o_pixel_r, o_pixel_g, o_pixel_b}), 0);
        @(negedge clk_50Mhz);
        @(negedge clk_50Mhz);
        chk("abort_sram", 32'(sram[200]), 32'(init_pix(200)));
        // The aborted write never reached memory.
        ref_mem[200] = init_pix(200);
        model_reset();
        host_mode = HOST_OFF;
        reset = 0;
        repeat (14) tick(0, 0);
        chk("post_rst_pix", 32'({o_pixel_r, o_pixel_g, o_pixel_b}), 32'(init_pix(0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
